// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares the byte-wide RAM port between instruction fetch and the
//            load/store unit. Expands 1/2/4-byte requests into little-endian
//            byte sequences, assembles/extends read data, pulses done.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rdy,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  clear,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  if_done,
  output logic [31:0]           if_inst,
  input  logic                  ls_req,
  input  logic                  ls_wr,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [1:0]            ls_width,
  input  logic                  ls_signed,
  input  logic [31:0]           ls_wdata,
  output logic                  ls_done,
  output logic [31:0]           ls_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [2:0]            n_q, n_d;
  logic [2:0]            ic_q, ic_d;
  logic [2:0]            cc_q, cc_d;
  logic [31:0]           asm_q, asm_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [1:0]            width_q, width_d;
  logic                  signed_q, signed_d;
  logic                  last_grant_q, last_grant_d;
  logic                  replay_q, replay_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic [31:0]           if_inst_q, if_inst_d;
  logic [31:0]           ls_rdata_q, ls_rdata_d;

  logic [31:0]           w_word;
  logic                  w_if_ok;
  logic [ADDR_WIDTH-1:0] w_ic_ext;
  logic [ADDR_WIDTH-1:0] w_cc_ext;

  assign w_ic_ext = {{(ADDR_WIDTH-3){1'b0}}, ic_q};
  assign w_cc_ext = {{(ADDR_WIDTH-3){1'b0}}, cc_q};
  assign if_inst  = if_inst_q;
  assign ls_rdata = ls_rdata_q;

  // Zero- or sign-extend an assembled load according to its width.
  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] width,
                                         input logic sgn);
    case (width)
      2'd0:    return {{24{sgn & w[7]}}, w[7:0]};
      2'd1:    return {{16{sgn & w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Arbitration, byte sequencing, read assembly and RAM/done output decode.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    base_d       = base_q;
    n_d          = n_q;
    ic_d         = ic_q;
    cc_d         = cc_q;
    asm_d        = asm_q;
    wdata_d      = wdata_q;
    width_d      = width_q;
    signed_d     = signed_q;
    last_grant_d = last_grant_q;
    replay_d     = replay_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    if_inst_d    = if_inst_q;
    ls_rdata_d   = ls_rdata_q;
    mem_a        = mem_a_q;
    mem_dout     = mem_dout_q;
    mem_wr       = 1'b0;
    if_done      = 1'b0;
    ls_done      = 1'b0;
    w_if_ok      = if_req & ~clear;

    // Assembly register with the incoming byte merged into lane cc.
    w_word = asm_q;
    case (cc_q[1:0])
      2'd0:    w_word[7:0]   = mem_din;
      2'd1:    w_word[15:8]  = mem_din;
      2'd2:    w_word[23:16] = mem_din;
      default: w_word[31:24] = mem_din;
    endcase

    if (rdy) begin
      case (state_q)
        S_IDLE: begin
          // LS wins when alone or when IF held the port last time.
          if (ls_req && (!w_if_ok || last_grant_q == OWN_IF)) begin
            owner_d  = OWN_LS;
            base_d   = ls_addr;
            width_d  = ls_width;
            signed_d = ls_signed;
            wdata_d  = ls_wdata;
            case (ls_width)
              2'd0:    n_d = 3'd1;
              2'd1:    n_d = 3'd2;
              default: n_d = 3'd4;
            endcase
            ic_d     = 3'd0;
            cc_d     = 3'd0;
            asm_d    = 32'd0;
            replay_d = 1'b0;
            state_d  = ls_wr ? S_WR : S_RD;
          end else if (w_if_ok) begin
            owner_d  = OWN_IF;
            base_d   = if_pc;
            width_d  = 2'd2;
            signed_d = 1'b0;
            n_d      = 3'd4;
            ic_d     = 3'd0;
            cc_d     = 3'd0;
            asm_d    = 32'd0;
            replay_d = 1'b0;
            state_d  = S_RD;
          end
        end
        S_RD: begin
          if (owner_q == OWN_IF && clear) begin
            state_d = S_IDLE;
          end else if (replay_q) begin
            // Byte at the frozen address was lost: re-present the next
            // uncaptured address and resume issuing after it.
            mem_a    = base_q + w_cc_ext;
            ic_d     = cc_q + 3'd1;
            replay_d = 1'b0;
          end else begin
            if (ic_q < n_q) begin
              mem_a = base_q + w_ic_ext;
              ic_d  = ic_q + 3'd1;
            end
            if (cc_q < ic_q) begin
              asm_d = w_word;
              cc_d  = cc_q + 3'd1;
              if (cc_q + 3'd1 == n_q) begin
                state_d = S_DONE;
                if (owner_q == OWN_IF) if_inst_d  = w_word;
                else                   ls_rdata_d = extend(w_word, width_q, signed_q);
              end
            end
          end
          mem_a_d = mem_a;
        end
        S_WR: begin
          mem_a  = base_q + w_ic_ext;
          mem_wr = 1'b1;
          case (ic_q[1:0])
            2'd0:    mem_dout = wdata_q[7:0];
            2'd1:    mem_dout = wdata_q[15:8];
            2'd2:    mem_dout = wdata_q[23:16];
            default: mem_dout = wdata_q[31:24];
          endcase
          mem_a_d    = mem_a;
          mem_dout_d = mem_dout;
          ic_d       = ic_q + 3'd1;
          if (ic_q == n_q - 3'd1) state_d = S_DONE;
        end
        default: begin
          if_done      = (owner_q == OWN_IF) && !clear;
          ls_done      = (owner_q == OWN_LS);
          last_grant_d = owner_q;
          state_d      = S_IDLE;
        end
      endcase
    end else if (state_q == S_RD) begin
      replay_d = 1'b1;
    end
  end

  // State and context registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IF;
      base_q       <= '0;
      n_q          <= 3'd0;
      ic_q         <= 3'd0;
      cc_q         <= 3'd0;
      asm_q        <= 32'd0;
      wdata_q      <= 32'd0;
      width_q      <= 2'd0;
      signed_q     <= 1'b0;
      last_grant_q <= OWN_IF;
      replay_q     <= 1'b0;
      mem_a_q      <= '0;
      mem_dout_q   <= 8'd0;
      if_inst_q    <= 32'd0;
      ls_rdata_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      base_q       <= base_d;
      n_q          <= n_d;
      ic_q         <= ic_d;
      cc_q         <= cc_d;
      asm_q        <= asm_d;
      wdata_q      <= wdata_d;
      width_q      <= width_d;
      signed_q     <= signed_d;
      last_grant_q <= last_grant_d;
      replay_q     <= replay_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      if_inst_q    <= if_inst_d;
      ls_rdata_q   <= ls_rdata_d;
    end
  end

endmodule
`default_nettype wire
